// File: rtl/mips_seq_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock.
// Optional macro MIPS_DIV_ZERO_FAST_EN: divide-by-zero skips the RUN phase.
module mips_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, rem, dvsr;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, trial;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg, dz;
  logic             last, dz_in;

  // Operand magnitudes, zero-divisor detect and one trial subtraction.
  always_comb begin
    mag_a   = dividend;
    mag_b   = divisor;
    if (is_signed && dividend[WIDTH-1])
      mag_a = -dividend;
    if (is_signed && divisor[WIDTH-1])
      mag_b = -divisor;
    dz_in   = (divisor == '0);
    last    = (cnt == CW'(WIDTH - 1));
    shifted = {rem, q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef MIPS_DIV_ZERO_FAST_EN
          state_n = dz_in ? FIX : RUN;
`else
          state_n = RUN;
`endif
        end
      end
      RUN:     if (last) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  assign busy = (state != IDLE);

  // Datapath: capture, shift/subtract, sign fix and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q           <= '0;
      rem         <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            q     <= mag_a;
            dvsr  <= mag_b;
            cnt   <= '0;
            q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= is_signed & dividend[WIDTH-1];
            dz    <= dz_in;
            // With a zero divisor the full loop leaves |dividend| in rem;
            // the fast path preloads it so FIX sees the same value.
`ifdef MIPS_DIV_ZERO_FAST_EN
            rem   <= dz_in ? mag_a : '0;
`else
            rem   <= '0;
`endif
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          // Negating |dividend| restores the raw dividend for div-by-zero.
          quotient    <= dz ? '1 : (q_neg ? -q : q);
          remainder   <= r_neg ? -rem : rem;
          div_by_zero <= dz;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_seq_divider.sv
// Directed self-checking bench for mips_seq_divider.
// Results checked with immediate assertions after each edge.
module tb_mips_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors;
  int miscompares;

`ifdef MIPS_DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  mips_seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic s, input logic [31:0] a,
                        input logic [31:0] b);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    tick();
    start     = 1'b0;
    is_signed = 1'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Counts edges after the accept edge until done; bounded.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (busy) nb++;
    end
  endtask

  task automatic do_op(input string tag, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] eq,
                       input logic [31:0] er, input logic edz);
    int n, nb;
    launch(s, a, b);
    wait_done(n, nb);
    chk({tag, " lat"}, 32'(n), 32'(lat));
    chk({tag, " q"}, quotient, eq);
    chk({tag, " r"}, remainder, er);
    chk({tag, " dz"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  initial begin
    int n, nb, pulses, total;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    is_signed   = 1'b0;
    dividend    = '0;
    divisor     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst q", quotient, 32'd0);
    chk("rst r", remainder, 32'd0);
    chk("rst dz", {31'd0, div_by_zero}, 32'd0);
    tick();

    launch(1'b0, 32'd100, 32'd7);
    wait_done(n, nb);
    chk("divu100/7 lat", 32'(n), 32'd33);
    chk("divu100/7 busy", 32'(nb), 32'd33);
    chk("divu100/7 q", quotient, 32'd14);
    chk("divu100/7 r", remainder, 32'd2);
    chk("divu100/7 dz", {31'd0, div_by_zero}, 32'd0);
    tick();
    chk("done pulse", {31'd0, done}, 32'd0);
    chk("q hold", quotient, 32'd14);

    do_op("div-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_op("div7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33,
          32'hFFFF_FFFD, 32'd1, 1'b0);
    do_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
          32'h8000_0000, 32'd0, 1'b0);
    do_op("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33,
          32'hFFFF_FFFF, 32'd0, 1'b0);
    do_op("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33,
          32'd0, 32'h8000_0000, 1'b0);
    do_op("divu5/0", 1'b0, 32'd5, 32'd0, ZLAT,
          32'hFFFF_FFFF, 32'd5, 1'b1);
    do_op("div5/0", 1'b1, 32'd5, 32'd0, ZLAT,
          32'hFFFF_FFFF, 32'd5, 1'b1);
    do_op("div-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, ZLAT,
          32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    do_op("div-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33,
          32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    launch(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    total = 10 + n;
    chk("ign lat", 32'(total), 32'd33);
    chk("ign q", quotient, 32'd14);
    chk("ign r", remainder, 32'd2);
    launch(1'b0, 32'd50, 32'd5);
    wait_done(n, nb);
    chk("b2b lat", 32'(n), 32'd33);
    chk("b2b q", quotient, 32'd10);
    chk("b2b r", remainder, 32'd0);

    launch(1'b0, 32'd100, 32'd7);
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort q", quotient, 32'd0);
    chk("abort r", remainder, 32'd0);
    chk("abort dz", {31'd0, div_by_zero}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    chk("abort quiet", 32'(pulses), 32'd0);
    do_op("post rst", 1'b0, 32'd9, 32'd4, 33, 32'd2, 32'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
